// File: rtl/bf_table_fill.sv
// Blowfish ExpandKey sequencer: chains 521 feistel encryptions and writes each result pair over P[] then S[] in SRAM.
// Build option: define SALT_EN to XOR the salt words into each block (EksBlowfish); otherwise the salt is ignored.
module bf_table_fill #(
  parameter int P_ARRAY_OFFSET = 4000,
  parameter int P_ENTRIES      = 18,
  parameter int S_ENTRIES      = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] salt,
  output logic         busy,
  output logic         done,
  output logic         fs_start,
  output logic [31:0]  fs_L,
  output logic [31:0]  fs_R,
  input  logic [31:0]  fs_resultL,
  input  logic [31:0]  fs_resultR,
  input  logic         fs_done,
  output logic         wr_en,
  output logic [11:0]  wr_addr,
  output logic [31:0]  wr_data
);

  localparam int         NUM_PAIRS = (P_ENTRIES + S_ENTRIES) / 2;
  localparam logic [9:0] LAST_PAIR = 10'(NUM_PAIRS - 1);

`ifdef SALT_EN
  localparam logic [31:0] SALT_MASK = '1;
`else
  localparam logic [31:0] SALT_MASK = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_MIX, S_LAUNCH, S_WAIT_F, S_WR_L, S_WR_R, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_L;
  logic [31:0] r_R;
  logic [9:0]  r_i;

  logic [31:0] w_wa;
  logic [31:0] w_wb;
  logic [11:0] w_addr_even;
  logic [11:0] w_addr_odd;

  // Word k of the combined table: P[] sits at the offset, S[] starts at address 0.
  function automatic logic [11:0] table_addr(input logic [10:0] k);
    if (k < 11'(P_ENTRIES))
      return 12'(P_ARRAY_OFFSET) + 12'(k);
    else
      return 12'(k) - 12'(P_ENTRIES);
  endfunction

  // Even pairs take salt words 0/1, odd pairs words 2/3.
  assign w_wa        = (r_i[0] ? salt[63:32] : salt[127:96]) & SALT_MASK;
  assign w_wb        = (r_i[0] ? salt[31:0]  : salt[95:64])  & SALT_MASK;
  assign w_addr_even = table_addr({r_i, 1'b0});
  assign w_addr_odd  = table_addr({r_i, 1'b1});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_L      <= '0;
      r_R      <= '0;
      r_i      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fs_start <= 1'b0;
      fs_L     <= '0;
      fs_R     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      fs_start <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_MIX;
            r_L     <= '0;
            r_R     <= '0;
            r_i     <= '0;
            busy    <= 1'b1;
          end
        end
        S_MIX: begin
          fs_L     <= r_L ^ w_wa;
          fs_R     <= r_R ^ w_wb;
          fs_start <= 1'b1;
          r_state  <= S_LAUNCH;
        end
        S_LAUNCH: r_state <= S_WAIT_F;
        S_WAIT_F: begin
          if (fs_done) begin
            r_L     <= fs_resultL;
            r_R     <= fs_resultR;
            wr_en   <= 1'b1;
            wr_addr <= w_addr_even;
            wr_data <= fs_resultL;
            r_state <= S_WR_L;
          end
        end
        S_WR_L: begin
          wr_en   <= 1'b1;
          wr_addr <= w_addr_odd;
          wr_data <= r_R;
          r_state <= S_WR_R;
        end
        S_WR_R: begin
          if (r_i == LAST_PAIR) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i + 10'd1;
            r_state <= S_MIX;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_table_fill.sv
// Directed bench for bf_table_fill with a 3-cycle stub feistel (identity or +1 transform).
module tb_bf_table_fill;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] salt;
  logic         busy, done, fs_start, fs_done, wr_en;
  logic [31:0]  fs_L, fs_R, fs_resultL, fs_resultR, wr_data;
  logic [11:0]  wr_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int stub_mode;   // 0: identity, 1: add one to each half
  int stub_cnt = 0;
  int done_cnt;
  int busy_seen;

  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] lf_q[$];
  logic [31:0] rf_q[$];

  always #5 clk = ~clk;

  bf_table_fill dut (
    .clk(clk), .reset(reset), .start(start), .salt(salt),
    .busy(busy), .done(done), .fs_start(fs_start), .fs_L(fs_L), .fs_R(fs_R),
    .fs_resultL(fs_resultL), .fs_resultR(fs_resultR), .fs_done(fs_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Stub feistel: done pulse three cycles after the start pulse is sampled.
  always @(posedge clk) begin
    fs_done <= 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) fs_done <= 1'b1;
    end
    if (fs_start) begin
      stub_cnt   <= 3;
      fs_resultL <= (stub_mode == 1) ? fs_L + 32'd1 : fs_L;
      fs_resultR <= (stub_mode == 1) ? fs_R + 32'd1 : fs_R;
    end
  end

  always @(posedge clk) begin
    #1;
    if (wr_en)    begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
    if (fs_start) begin lf_q.push_back(fs_L);    rf_q.push_back(fs_R);    end
    if (done)     done_cnt++;
    if (busy)     busy_seen = 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); lf_q.delete(); rf_q.delete();
    done_cnt  = 0;
    busy_seen = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk) reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int t = 0;
    while (wa_q.size() < n && t < budget) begin @(negedge clk); t++; end
    if (wa_q.size() < n) check({tag, "_timeout"}, 64'(wa_q.size()), 64'(n));
  endtask

  task automatic wait_launches(input int n, input int budget, input string tag);
    int t = 0;
    while (lf_q.size() < n && t < budget) begin @(negedge clk); t++; end
    if (lf_q.size() < n) check({tag, "_timeout"}, 64'(lf_q.size()), 64'(n));
  endtask

  task automatic check_write(input string tag, input int idx, input logic [11:0] a, input logic [31:0] d);
    if (idx < wa_q.size()) begin
      check({tag, "_addr"}, 64'(wa_q[idx]), 64'(a));
      check({tag, "_data"}, 64'(wd_q[idx]), 64'(d));
    end else begin
      check({tag, "_missing"}, 64'(wa_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    logic [31:0] exp_w;
    int t;
    reset = 1'b0; start = 1'b0; salt = '0; stub_mode = 1;
    clear_log();

    // Reset state
    do_reset(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fs_start", 64'(fs_start), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_fs_L", 64'(fs_L), 64'd0);
    check("rst_fs_R", 64'(fs_R), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);

    // +1 stub, salt 0, full run: pair p writes p+1 to both words
    clear_log();
    pulse_start();
    wait_writes(1042, 12000, "full");
    repeat (4) @(negedge clk);
    check_write("p0_L", 0, 12'd4000, 32'd1);
    check_write("p0_R", 1, 12'd4001, 32'd1);
    if (lf_q.size() > 1) begin
      check("p1_fs_L", 64'(lf_q[1]), 64'd1);
      check("p1_fs_R", 64'(rf_q[1]), 64'd1);
    end else check("p1_launch_missing", 64'(lf_q.size()), 64'd2);
    check_write("p1_L", 2, 12'd4002, 32'd2);
    check_write("p1_R", 3, 12'd4003, 32'd2);
    check_write("p8_L", 16, 12'd4016, 32'd9);
    check_write("p8_R", 17, 12'd4017, 32'd9);
    check_write("p9_L", 18, 12'd0, 32'd10);
    check_write("p9_R", 19, 12'd1, 32'd10);
    check_write("p520_L", 1040, 12'd1022, 32'd521);
    check_write("p520_R", 1041, 12'd1023, 32'd521);
    check("wr_pulses", 64'(wa_q.size()), 64'd1042);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_seen", 64'(busy_seen), 64'd1);
    check("busy_after", 64'(busy), 64'd0);

    // Salted identity stub: first two launches
    stub_mode = 0;
    salt = {32'h1, 32'h2, 32'h3, 32'h4};
    do_reset(1);
    clear_log();
    pulse_start();
    wait_launches(2, 100, "salt");
`ifdef SALT_EN
    if (lf_q.size() > 1) begin
      check("salt_p0_fs_L", 64'(lf_q[0]), 64'd1);
      check("salt_p0_fs_R", 64'(rf_q[0]), 64'd2);
      check("salt_p1_fs_L", 64'(lf_q[1]), 64'd2);
      check("salt_p1_fs_R", 64'(rf_q[1]), 64'd6);
    end
`else
    if (lf_q.size() > 1) begin
      check("nosalt_p0_fs_L", 64'(lf_q[0]), 64'd0);
      check("nosalt_p0_fs_R", 64'(rf_q[0]), 64'd0);
      check("nosalt_p1_fs_L", 64'(lf_q[1]), 64'd0);
      check("nosalt_p1_fs_R", 64'(rf_q[1]), 64'd0);
    end
`endif

    // All-ones salt, identity stub: first four pairs
    salt = '1;
    do_reset(1);
    clear_log();
    pulse_start();
    wait_writes(8, 200, "ones");
    for (int k = 0; k < 8; k++) begin
`ifdef SALT_EN
      exp_w = ((k / 2) % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
`else
      exp_w = 32'h0;
`endif
      if (k < wd_q.size()) check($sformatf("ones_w%0d", k), 64'(wd_q[k]), 64'(exp_w));
    end

    // start while busy ignored, then reset during WAIT_F
    stub_mode = 1;
    salt = '0;
    do_reset(1);
    clear_log();
    pulse_start();
    wait_launches(1, 50, "busy_start");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_writes(4, 100, "busy_start");
    check_write("ign_w2", 2, 12'd4002, 32'd2);
    check_write("ign_w3", 3, 12'd4003, 32'd2);
    t = 0;
    while (!fs_start && t < 50) begin @(negedge clk); t++; end
    check("launch_seen", 64'(fs_start), 64'd1);
    @(negedge clk);              // now in WAIT_F
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    clear_log();
    repeat (8) @(negedge clk);   // stale stub done arrives while idle
    check("idle_no_writes", 64'(wa_q.size()), 64'd0);
    pulse_start();
    wait_writes(2, 100, "restart");
    check_write("restart_w0", 0, 12'd4000, 32'd1);
    check_write("restart_w1", 1, 12'd4001, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
